biriscv_mul_issue_ctrl: RTL and testbench
=========================================

// Module: biriscv_mul_issue_ctrl
// PURPOSE
// - Shares the combinational radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU) between the two issue lanes of the dual-issue core.
// - Arbitrates one request per cycle, registers operands into the multiplier and pipelines the result.
// - Returns lane, tag and value to writeback, with stall (hold) and flush support.
// PARAMETERS
// - TAG_W       default 5  width of the requester tag (rd index) carried to writeback
// - MUL_STAGES  default 2  grant-to-writeback latency in cycles; legal range 1..4
// PORTS
// - clk_i              in   1      clock
// - rst_i              in   1      asynchronous reset, active-high
// - hold_i             in   1      pipeline stall; freezes all state
// - flush_i            in   1      kill every in-flight multiply
// - req0_valid_i       in   1      lane 0 request
// - req0_opcode_i      in   32     lane 0 instruction word
// - req0_ra_i          in   32     lane 0 rs1 value
// - req0_rb_i          in   32     lane 0 rs2 value
// - req0_tag_i         in   TAG_W  lane 0 tag
// - req0_grant_o       out  1      lane 0 accepted this cycle
// - req1_*             same as req0_* for lane 1
// - mul_opcode_o       out  32     registered opcode to multiplier
// - mul_ra_o           out  32     registered operand A to multiplier
// - mul_rb_o           out  32     registered operand B to multiplier
// - mul_result_i       in   32     multiplier writeback value (combinational from mul_*_o)
// - wb_valid_o         out  1      result valid
// - wb_lane_o          out  1      originating lane
// - wb_tag_o           out  TAG_W  originating tag
// - wb_value_o         out  32     result
// - busy_o             out  1      any stage holds a valid op
// - conflict_cnt_o     out  32     perf counter (see CONFIGURATION)
// BEHAVIOUR
// - Eligible request: valid and opcode[6:0]=0110011, [31:25]=0000001, [14]=0. DIV/REM are never granted.
// - grant = eligible & !hold_i & !flush_i; combinational; at most one grant per cycle.
// - Both eligible: round-robin; grant the lane not granted last. last_grant resets to 1 (lane 0 wins first). A single eligible lane is granted unconditionally and updates last_grant.
// - Stage S1 (edge ending grant cycle T): captures opcode, ra, rb, tag, lane and valid into mul_*_o.
// - Stages S2..S_MUL_STAGES: delay mul_result_i together with valid/lane/tag.
// - wb_* are valid during cycle T+MUL_STAGES.
//   - MUL_STAGES=1: wb_value_o = mul_result_i (combinational from S1).
//   - MUL_STAGES>=2: wb_value_o is registered.
// - Throughput: one op per cycle, fully pipelined; no backpressure besides hold_i.
// - hold_i=1: no grants; all stage registers, last_grant and wb_* keep their values (wb_valid_o stays asserted if set).
// - flush_i=1: no grants; all stage valid bits, including wb_valid_o, clear at the next edge. Data registers need not clear. flush_i has priority over hold_i.
// - Reset (any time, including mid-operation) clears:
//   - all valid bits, wb_valid_o, wb_lane_o, wb_tag_o, wb_value_o, mul_*_o, busy_o and conflict_cnt_o to 0;
//   - last_grant to 1.
// - busy_o = OR of all stage valid bits.
// - Unused lane (no request): no effect on arbitration state.
// CONFIGURATION
// - Macro MUL_CONFLICT_CNT_EN:
//   - defined: conflict_cnt_o increments, saturating at 0xFFFFFFFF, in every cycle where both lanes are eligible and grants are not suppressed (one lane denied).
//   - undefined: the counter is not built; conflict_cnt_o is tied to 0.
// TESTING
// - Lane 0 MUL 7*6, tag 3, MUL_STAGES=2 -> grant0 in T; wb_valid, lane0, tag3, value 42 in T+2.
// - Both lanes MULHU 0xFFFFFFFF*0xFFFFFFFF each cycle for 4 cycles after reset:
//   - grants alternate 0,1,0,1;
//   - wb values 0xFFFFFFFE back-to-back;
//   - conflict_cnt_o=4 with MUL_CONFLICT_CNT_EN.
// - Lane 1 DIV opcode (funct3=100) valid -> no grant, no wb_valid; lane 0 MULH -2*3 same cycle -> granted, value 0xFFFFFFFF.
// - MULHSU -1*2 issued, hold_i high 3 cycles at T+1 -> S1 frozen; wb appears at T+5, value 0xFFFFFFFF, exactly once.
// - Three back-to-back MULs, flush_i at T+1 -> only the first op (wb at T+2) survives? No: all in flight clear; wb_valid_o=0 from T+2, busy_o=0 at T+2.
// - rst_i asserted asynchronously with 2 ops in flight -> all outputs 0 immediately; after release, lane 0 wins first conflict.

Source files
------------

// File: rtl/biriscv_mul_issue_ctrl.sv
// Dual-lane issue control for the shared multiplier: round-robin grant, operand register, result pipeline.
// Optional perf counter of arbitration conflicts is built when MUL_CONFLICT_CNT_EN is defined.
module biriscv_mul_issue_ctrl #(
  parameter int TAG_W      = 5,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             req0_valid_i,
  input  logic [31:0]      req0_opcode_i,
  input  logic [31:0]      req0_ra_i,
  input  logic [31:0]      req0_rb_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  output logic             req0_grant_o,
  input  logic             req1_valid_i,
  input  logic [31:0]      req1_opcode_i,
  input  logic [31:0]      req1_ra_i,
  input  logic [31:0]      req1_rb_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             req1_grant_o,
  output logic [31:0]      mul_opcode_o,
  output logic [31:0]      mul_ra_o,
  output logic [31:0]      mul_rb_o,
  input  logic [31:0]      mul_result_i,
  output logic             wb_valid_o,
  output logic             wb_lane_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic [31:0]      wb_value_o,
  output logic             busy_o,
  output logic [31:0]      conflict_cnt_o
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  logic             elig0, elig1, issue_ok, issue_any;
  logic             grant0, grant1;
  logic             last_grant_q, last_grant_d;
  logic             s1_valid_q, s1_lane_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [31:0]      s1_opcode_q, s1_ra_q, s1_rb_q;
  logic             pipe_busy;

  // bit 14 separates MUL* (funct3 0..3) from DIV/REM (funct3 4..7)
  assign elig0 = req0_valid_i && (req0_opcode_i[6:0] == OPC_OP) &&
                 (req0_opcode_i[31:25] == F7_MULDIV) && !req0_opcode_i[14];
  assign elig1 = req1_valid_i && (req1_opcode_i[6:0] == OPC_OP) &&
                 (req1_opcode_i[31:25] == F7_MULDIV) && !req1_opcode_i[14];

  assign issue_ok = !hold_i && !flush_i && !rst_i;

  always_comb begin
    grant0       = 1'b0;
    grant1       = 1'b0;
    last_grant_d = last_grant_q;
    if (issue_ok) begin
      if (elig0 && elig1) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
    if (grant0)      last_grant_d = 1'b0;
    else if (grant1) last_grant_d = 1'b1;
  end

  assign req0_grant_o = grant0;
  assign req1_grant_o = grant1;
  assign issue_any    = grant0 || grant1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_lane_q    <= 1'b0;
      s1_tag_q     <= '0;
      s1_opcode_q  <= '0;
      s1_ra_q      <= '0;
      s1_rb_q      <= '0;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
    end else if (!hold_i) begin
      last_grant_q <= last_grant_d;
      s1_valid_q   <= issue_any;
      if (issue_any) begin
        s1_lane_q   <= grant1;
        s1_tag_q    <= grant1 ? req1_tag_i    : req0_tag_i;
        s1_opcode_q <= grant1 ? req1_opcode_i : req0_opcode_i;
        s1_ra_q     <= grant1 ? req1_ra_i     : req0_ra_i;
        s1_rb_q     <= grant1 ? req1_rb_i     : req0_rb_i;
      end
    end
  end

  assign mul_opcode_o = s1_opcode_q;
  assign mul_ra_o     = s1_ra_q;
  assign mul_rb_o     = s1_rb_q;

  generate
    if (MUL_STAGES == 1) begin : g_comb
      assign wb_valid_o = s1_valid_q;
      assign wb_lane_o  = s1_lane_q;
      assign wb_tag_o   = s1_tag_q;
      assign wb_value_o = mul_result_i;
      assign pipe_busy  = 1'b0;
    end else begin : g_pipe
      localparam int P = MUL_STAGES - 1;
      logic [P-1:0]     v_q;
      logic [P-1:0]     lane_q;
      logic [TAG_W-1:0] tag_q [P];
      logic [31:0]      val_q [P];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          v_q    <= '0;
          lane_q <= '0;
          for (int i = 0; i < P; i++) begin
            tag_q[i] <= '0;
            val_q[i] <= '0;
          end
        end else if (flush_i) begin
          v_q <= '0;
        end else if (!hold_i) begin
          v_q[0]    <= s1_valid_q;
          lane_q[0] <= s1_lane_q;
          tag_q[0]  <= s1_tag_q;
          val_q[0]  <= mul_result_i;
          for (int i = 1; i < P; i++) begin
            v_q[i]    <= v_q[i-1];
            lane_q[i] <= lane_q[i-1];
            tag_q[i]  <= tag_q[i-1];
            val_q[i]  <= val_q[i-1];
          end
        end
      end

      assign wb_valid_o = v_q[P-1];
      assign wb_lane_o  = lane_q[P-1];
      assign wb_tag_o   = tag_q[P-1];
      assign wb_value_o = val_q[P-1];
      assign pipe_busy  = |v_q;
    end
  endgenerate

  assign busy_o = s1_valid_q || pipe_busy;

`ifdef MUL_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      conflict_cnt_q <= '0;
    else if (issue_ok && elig0 && elig1 && (conflict_cnt_q != 32'hFFFF_FFFF))
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
  end
  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_biriscv_mul_issue_ctrl.sv
// Randomized bench for biriscv_mul_issue_ctrl against an age-list reference model.
module tb_biriscv_mul_issue_ctrl;
  localparam int TAG_W = 5;
  localparam int STG   = 2;

  logic clk_i = 1'b0, rst_i = 1'b1, hold_i = 1'b0, flush_i = 1'b0;
  logic req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic [31:0] req0_opcode_i = '0, req0_ra_i = '0, req0_rb_i = '0;
  logic [31:0] req1_opcode_i = '0, req1_ra_i = '0, req1_rb_i = '0;
  logic [TAG_W-1:0] req0_tag_i = '0, req1_tag_i = '0;
  logic req0_grant_o, req1_grant_o;
  logic [31:0] mul_opcode_o, mul_ra_o, mul_rb_o, mul_result_i;
  logic wb_valid_o, wb_lane_o, busy_o;
  logic [TAG_W-1:0] wb_tag_o;
  logic [31:0] wb_value_o, conflict_cnt_o;

  int total = 0, bad = 0;

  biriscv_mul_issue_ctrl #(.TAG_W(TAG_W), .MUL_STAGES(STG)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .req0_valid_i(req0_valid_i), .req0_opcode_i(req0_opcode_i), .req0_ra_i(req0_ra_i),
    .req0_rb_i(req0_rb_i), .req0_tag_i(req0_tag_i), .req0_grant_o(req0_grant_o),
    .req1_valid_i(req1_valid_i), .req1_opcode_i(req1_opcode_i), .req1_ra_i(req1_ra_i),
    .req1_rb_i(req1_rb_i), .req1_tag_i(req1_tag_i), .req1_grant_o(req1_grant_o),
    .mul_opcode_o(mul_opcode_o), .mul_ra_o(mul_ra_o), .mul_rb_o(mul_rb_o),
    .mul_result_i(mul_result_i), .wb_valid_o(wb_valid_o), .wb_lane_o(wb_lane_o),
    .wb_tag_o(wb_tag_o), .wb_value_o(wb_value_o), .busy_o(busy_o),
    .conflict_cnt_o(conflict_cnt_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mul_calc(input logic [31:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'd0, a};       ub = {32'd0, b};
    case (op[13:12])
      2'd0:    p = ua * ub;
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op[13:12] == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  always_comb mul_result_i = mul_calc(mul_opcode_o, mul_ra_o, mul_rb_o);

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic bit is_mul(input logic v, input logic [31:0] op);
    return v && op[6:0] == 7'b0110011 && op[31:25] == 7'b0000001 && op[14:12] < 3'd4;
  endfunction

  typedef struct {
    int               age;
    bit               lane;
    logic [TAG_W-1:0] tag;
    logic [31:0]      val;
  } op_t;
  op_t q[$];
  bit m_last = 1'b1;
  longint m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v0, input logic [31:0] o0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic [TAG_W-1:0] t0,
                       input bit v1, input logic [31:0] o1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [TAG_W-1:0] t1,
                       input bit h, input bit f);
    req0_valid_i = v0; req0_opcode_i = o0; req0_ra_i = a0; req0_rb_i = b0; req0_tag_i = t0;
    req1_valid_i = v1; req1_opcode_i = o1; req1_ra_i = a1; req1_rb_i = b1; req1_tag_i = t1;
    hold_i = h; flush_i = f;
  endtask

  task automatic idle(input bit h, input bit f);
    drive(0, '0, '0, '0, '0, 0, '0, '0, '0, '0, h, f);
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one clock.
  task automatic cycle();
    bit e0, e1, g0, g1, ok, wv;
    op_t w;
    #1;
    e0 = is_mul(req0_valid_i, req0_opcode_i);
    e1 = is_mul(req1_valid_i, req1_opcode_i);
    ok = !hold_i && !flush_i;
    g0 = ok && e0 && (!e1 || m_last);
    g1 = ok && e1 && (!e0 || !m_last);
    check("grant0", req0_grant_o, g0);
    check("grant1", req1_grant_o, g1);
    wv = 0;
    foreach (q[i]) if (q[i].age == STG) begin wv = 1; w = q[i]; end
    check("wb_valid", wb_valid_o, wv);
    if (wv) begin
      check("wb_lane", wb_lane_o, w.lane);
      check("wb_tag", wb_tag_o, w.tag);
      check("wb_value", wb_value_o, w.val);
    end
    check("busy", busy_o, q.size() != 0);
`ifdef MUL_CONFLICT_CNT_EN
    check("conflict_cnt", conflict_cnt_o, m_cnt);
`else
    check("conflict_cnt", conflict_cnt_o, 0);
`endif
    @(posedge clk_i);
    if (flush_i) q.delete();
    else if (!hold_i) begin
      foreach (q[i]) q[i].age++;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].age > STG) q.delete(i);
      if (g0) q.push_back('{1, 1'b0, req0_tag_i, mul_calc(req0_opcode_i, req0_ra_i, req0_rb_i)});
      if (g1) q.push_back('{1, 1'b1, req1_tag_i, mul_calc(req1_opcode_i, req1_ra_i, req1_rb_i)});
      if (g0) m_last = 1'b0;
      if (g1) m_last = 1'b1;
      if (e0 && e1 && m_cnt != 64'hFFFF_FFFF) m_cnt++;
    end
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wbv"}, wb_valid_o, 0);
    check({tag, "_wbl"}, wb_lane_o, 0);
    check({tag, "_wbt"}, wb_tag_o, 0);
    check({tag, "_wbd"}, wb_value_o, 0);
    check({tag, "_mul"}, {mul_opcode_o, mul_ra_o | mul_rb_o}, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_cnt"}, conflict_cnt_o, 0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_reset_outputs(tag);
    q.delete(); m_last = 1'b1; m_cnt = 0;
    @(negedge clk_i);
    idle(0, 0);
    rst_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_opcode();
    int k = $urandom_range(0, 9);
    if (k < 6) return enc(7'b0000001, 3'(k % 4));
    if (k < 8) return enc(7'b0000001, 3'($urandom_range(4, 7)));
    if (k == 8) return enc(7'b0000000, 3'd0);
    return $urandom;
  endfunction

  localparam logic [31:0] OP_MUL    = 32'h0220_81B3;
  localparam logic [31:0] OP_MULH   = 32'h0220_91B3;
  localparam logic [31:0] OP_MULHSU = 32'h0220_A1B3;
  localparam logic [31:0] OP_MULHU  = 32'h0220_B1B3;
  localparam logic [31:0] OP_DIV    = 32'h0220_C1B3;

  initial begin
    idle(0, 0);
    repeat (2) @(negedge clk_i);
    check_reset_outputs("por");
    rst_i = 1'b0;

    // 7*6 on lane 0, tag 3
    drive(1, OP_MUL, 7, 6, 3, 0, '0, '0, '0, '0, 0, 0); cycle();
    idle(0, 0); cycle();
    check("mul42_value", wb_value_o, 42);
    cycle(); cycle();

    // Fresh reset, then four cycles of dual MULHU conflicts
    async_reset("rst_a");
    for (int i = 0; i < 4; i++) begin
      drive(1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i),
            1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i + 8), 0, 0);
      cycle();
    end
    idle(0, 0);
    check("mulhu_value", wb_value_o, 32'hFFFF_FFFE);
`ifdef MUL_CONFLICT_CNT_EN
    check("conflict4", conflict_cnt_o, 4);
`endif
    repeat (3) cycle();

    // DIV on lane 1 ignored, MULH on lane 0 granted
    drive(1, OP_MULH, 32'hFFFF_FFFE, 3, 7, 1, OP_DIV, 10, 2, 9, 0, 0); cycle();
    idle(0, 0); cycle();
    check("mulh_value", wb_value_o, 32'hFFFF_FFFF);
    repeat (2) cycle();

    // MULHSU, then three hold cycles
    drive(1, OP_MULHSU, 32'hFFFF_FFFF, 2, 4, 0, '0, '0, '0, '0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin idle(1, 0); cycle(); end
    idle(0, 0); cycle();
    check("hold_wb_valid", wb_valid_o, 1);
    check("hold_value", wb_value_o, 32'hFFFF_FFFF);
    repeat (3) cycle();

    // Three back-to-back MULs with flush on the second cycle
    drive(1, OP_MUL, 3, 5, 1, 0, '0, '0, '0, '0, 0, 0); cycle();
    drive(1, OP_MUL, 4, 5, 2, 0, '0, '0, '0, '0, 0, 1); cycle();
    drive(1, OP_MUL, 6, 5, 3, 0, '0, '0, '0, '0, 0, 0); cycle();
    repeat (3) begin idle(0, 0); cycle(); end

    // Async reset with two ops in flight, then lane 0 must win first conflict
    drive(1, OP_MUL, 9, 9, 1, 0, '0, '0, '0, '0, 0, 0); cycle();
    drive(0, '0, '0, '0, '0, 1, OP_MUL, 8, 8, 2, 0, 0); cycle();
    async_reset("rst_b");
    drive(1, OP_MUL, 2, 2, 1, 1, OP_MUL, 3, 3, 2, 0, 0); cycle();
    repeat (3) begin idle(0, 0); cycle(); end

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_reset("rst_r");
      drive($urandom_range(0, 3) != 0, rand_opcode(), rand_operand(), rand_operand(),
            TAG_W'($urandom), $urandom_range(0, 3) != 0, rand_opcode(), rand_operand(),
            rand_operand(), TAG_W'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
